stream_packer: RTL and testbench

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer.sv | 152 +++++++++++++++
 tb/tb_stream_packer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// stream_packer: packs RATIO narrow stream beats into one OUT_WIDTH word, lane 0 in the LSBs.
// Define STREAM_PACKER_KEEP_EN to add the m_out_tkeep lane qualifier output.
module stream_packer #(
    parameter int IN_WIDTH = 32,
    parameter int RATIO = 4,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  s_in_tdata,
    input  logic                 s_in_tvalid,
    input  logic                 s_in_tlast,
    output logic                 s_in_tready,
    output logic [OUT_WIDTH-1:0] m_out_tdata,
    output logic                 m_out_tvalid,
    output logic                 m_out_tlast,
`ifdef STREAM_PACKER_KEEP_EN
    output logic [RATIO-1:0]     m_out_tkeep,
`endif
    input  logic                 m_out_tready
);

    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [CW-1:0]          cnt_r, cnt_nxt_s;
    logic [OUT_WIDTH-1:0]   asm_r, asm_nxt_s, merge_s;
    logic [OUT_WIDTH-1:0]   out_data_r, out_data_nxt_s;
    logic                   out_last_r, out_last_nxt_s;
    logic                   out_valid_r;
    logic                   in_ready_s, in_xfer_s, out_xfer_s, close_s;

    // The word can advance whenever the output slot is empty or draining this cycle.
    assign in_ready_s   = ~rst & (~out_valid_r | m_out_tready);
    assign in_xfer_s    = s_in_tvalid & in_ready_s;
    assign out_xfer_s   = out_valid_r & m_out_tready;
    assign close_s      = in_xfer_s & ((cnt_r == LAST_LANE) | s_in_tlast);

    assign s_in_tready  = in_ready_s;
    assign m_out_tdata  = out_data_r;
    assign m_out_tvalid = out_valid_r;
    assign m_out_tlast  = out_last_r;

    // Assembly register with the current beat dropped into the selected lane.
    always_comb begin
        merge_s = asm_r;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt_r == CW'(k)) begin
                merge_s[k*IN_WIDTH +: IN_WIDTH] = s_in_tdata;
            end else begin
                merge_s[k*IN_WIDTH +: IN_WIDTH] = asm_r[k*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // Next-state: HOLD while a word is registered; a closing beat refills it even while draining.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FILL: begin
                if (close_s) begin
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_FILL;
                end
            end
            S_HOLD: begin
                if (close_s) begin
                    state_nxt_s = S_HOLD;
                end else if (out_xfer_s) begin
                    state_nxt_s = S_FILL;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            default: state_nxt_s = S_FILL;
        endcase
    end

    // Datapath next values for lane counter, assembly and output registers.
    always_comb begin
        cnt_nxt_s      = cnt_r;
        asm_nxt_s      = asm_r;
        out_data_nxt_s = out_data_r;
        out_last_nxt_s = out_last_r;
        if (close_s) begin
            cnt_nxt_s      = {CW{1'b0}};
            asm_nxt_s      = {OUT_WIDTH{1'b0}};
            out_data_nxt_s = merge_s;
            out_last_nxt_s = s_in_tlast;
        end else if (in_xfer_s) begin
            cnt_nxt_s = cnt_r + CW'(1);
            asm_nxt_s = merge_s;
            if (out_xfer_s) begin
                out_last_nxt_s = 1'b0;
            end else begin
                out_last_nxt_s = out_last_r;
            end
        end else if (out_xfer_s) begin
            out_last_nxt_s = 1'b0;
        end else begin
            out_last_nxt_s = out_last_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_FILL;
            cnt_r       <= {CW{1'b0}};
            asm_r       <= {OUT_WIDTH{1'b0}};
            out_data_r  <= {OUT_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            asm_r       <= asm_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_last_r  <= out_last_nxt_s;
            out_valid_r <= (state_nxt_s == S_HOLD);
        end
    end

`ifdef STREAM_PACKER_KEEP_EN
    logic [RATIO-1:0] asm_keep_r, out_keep_r;
    logic [RATIO-1:0] keep_merge_s;

    assign keep_merge_s = asm_keep_r | (RATIO'(1) << cnt_r);
    assign m_out_tkeep  = out_keep_r;

    // Lane-written flags travel alongside the assembly and output data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_keep_r <= {RATIO{1'b0}};
            out_keep_r <= {RATIO{1'b0}};
        end else if (close_s) begin
            asm_keep_r <= {RATIO{1'b0}};
            out_keep_r <= keep_merge_s;
        end else if (in_xfer_s) begin
            asm_keep_r <= keep_merge_s;
        end
    end
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: directed scenarios plus randomized traffic
// against a beat-list reference model. Honours STREAM_PACKER_KEEP_EN when defined.
module tb_stream_packer;

    localparam int IN_W  = 32;
    localparam int RAT   = 4;
    localparam int OUT_W = IN_W * RAT;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  s_in_tdata;
    logic             s_in_tvalid;
    logic             s_in_tlast;
    logic             s_in_tready;
    logic [OUT_W-1:0] m_out_tdata;
    logic             m_out_tvalid;
    logic             m_out_tlast;
    logic             m_out_tready;
`ifdef STREAM_PACKER_KEEP_EN
    logic [RAT-1:0]   m_out_tkeep;
`endif

    stream_packer #(.IN_WIDTH(IN_W), .RATIO(RAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_in_tdata   (s_in_tdata),
        .s_in_tvalid  (s_in_tvalid),
        .s_in_tlast   (s_in_tlast),
        .s_in_tready  (s_in_tready),
        .m_out_tdata  (m_out_tdata),
        .m_out_tvalid (m_out_tvalid),
        .m_out_tlast  (m_out_tlast),
`ifdef STREAM_PACKER_KEEP_EN
        .m_out_tkeep  (m_out_tkeep),
`endif
        .m_out_tready (m_out_tready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stalls = 0;
    bit armed = 1'b0;
    bit rand_done = 1'b0;

    // Reference model state: beats accepted into the word under construction, and the expected output slot.
    logic [IN_W-1:0]  beats[$];
    logic             exp_valid = 1'b0;
    logic             exp_last = 1'b0;
    logic [OUT_W-1:0] exp_data = '0;
    logic [RAT-1:0]   exp_keep = '0;

    logic [OUT_W-1:0] got_words[$];
    logic             got_last[$];
    logic [RAT-1:0]   got_keep[$];
    int               got_cyc[$];

    task automatic check_val(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare outputs with the model, log transfers, then advance the model by this cycle's handshakes.
    always @(negedge clk) begin
        logic in_x, out_x;
        if (armed) begin
            check_val("in_ready", s_in_tready, !rst && (!exp_valid || m_out_tready));
            check_val("out_valid", m_out_tvalid, exp_valid);
            if (exp_valid) begin
                check_val("out_data", m_out_tdata, exp_data);
                check_val("out_last", m_out_tlast, exp_last);
`ifdef STREAM_PACKER_KEEP_EN
                check_val("out_keep", m_out_tkeep, exp_keep);
`endif
            end
            if (m_out_tvalid && m_out_tready && !rst) begin
                got_words.push_back(m_out_tdata);
                got_last.push_back(m_out_tlast);
`ifdef STREAM_PACKER_KEEP_EN
                got_keep.push_back(m_out_tkeep);
`else
                got_keep.push_back('0);
`endif
                got_cyc.push_back(cyc);
            end
        end
        if (rst) begin
            beats.delete();
            exp_valid = 1'b0;
            exp_last  = 1'b0;
            armed     = 1'b1;
        end else if (armed) begin
            out_x = exp_valid && m_out_tready;
            in_x  = s_in_tvalid && (!exp_valid || m_out_tready);
            if (in_x) begin
                beats.push_back(s_in_tdata);
                if (beats.size() == RAT || s_in_tlast) begin
                    exp_data = '0;
                    for (int k = 0; k < beats.size(); k++)
                        exp_data = exp_data | (OUT_W'(beats[k]) << (IN_W * k));
                    exp_keep  = RAT'((1 << beats.size()) - 1);
                    exp_valid = 1'b1;
                    exp_last  = s_in_tlast;
                    beats.delete();
                end else if (out_x) begin
                    exp_valid = 1'b0;
                    exp_last  = 1'b0;
                end
            end else if (out_x) begin
                exp_valid = 1'b0;
                exp_last  = 1'b0;
            end
        end
    end

    task automatic send_beat(input logic [IN_W-1:0] data, input logic last);
        int waited = 0;
        s_in_tdata  = data;
        s_in_tlast  = last;
        s_in_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_in_tready) break;
            waited++;
            stalls++;
            if (waited > 200) begin
                check_val("send_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_in_tvalid = 1'b0;
        s_in_tlast  = 1'b0;
    endtask

    // Idle cycles drive junk data and tlast to show they are ignored without valid.
    task automatic idle(input int n);
        s_in_tvalid = 1'b0;
        repeat (n) begin
            s_in_tdata = $urandom;
            s_in_tlast = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        s_in_tlast = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int base, st0, w;
        rst = 1'b1; s_in_tdata = '0; s_in_tvalid = 1'b0; s_in_tlast = 1'b0; m_out_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", m_out_tvalid, 1'b0);
        check_val("rst_data", m_out_tdata, '0);
        check_val("rst_last", m_out_tlast, 1'b0);
        check_val("rst_in_ready", s_in_tready, 1'b0);
`ifdef STREAM_PACKER_KEEP_EN
        check_val("rst_keep", m_out_tkeep, '0);
`endif
        rst = 1'b0;
        idle(2);

        // Four full lanes, no tlast.
        m_out_tready = 1'b1;
        base = got_words.size();
        send_beat(32'h11, 1'b0); send_beat(32'h22, 1'b0); send_beat(32'h33, 1'b0); send_beat(32'h44, 1'b0);
        idle(3);
        check_val("full_count", got_words.size() - base, 1);
        if (got_words.size() > base) begin
            check_val("full_word", got_words[base], 128'h00000044_00000033_00000022_00000011);
            check_val("full_last", got_last[base], 1'b0);
        end

        // Short packet padded with zeros.
        base = got_words.size();
        send_beat(32'hA, 1'b0); send_beat(32'hB, 1'b1);
        idle(3);
        check_val("short_count", got_words.size() - base, 1);
        if (got_words.size() > base) begin
            check_val("short_word", got_words[base], 128'h00000000_00000000_0000000B_0000000A);
            check_val("short_last", got_last[base], 1'b1);
`ifdef STREAM_PACKER_KEEP_EN
            check_val("short_keep", got_keep[base], 4'b0011);
`endif
        end

        // Single-beat packet.
        base = got_words.size();
        send_beat(32'h5, 1'b1);
        idle(3);
        check_val("single_count", got_words.size() - base, 1);
        if (got_words.size() > base) begin
            check_val("single_word", got_words[base], 128'h5);
            check_val("single_last", got_last[base], 1'b1);
        end

        // Back-pressure: downstream stalls once the first word is valid.
        m_out_tready = 1'b0;
        base = got_words.size();
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(32'h100 + 32'(i), 1'b0);
            end
            begin
                w = 0;
                while (!m_out_tvalid && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                check_val("bp_valid_seen", m_out_tvalid, 1'b1);
                repeat (4) @(negedge clk);
                check_val("bp_in_ready", s_in_tready, 1'b0);
                check_val("bp_hold_data", m_out_tdata, 128'h00000103_00000102_00000101_00000100);
                check_val("bp_hold_valid", m_out_tvalid, 1'b1);
                @(posedge clk);
                #1;
                m_out_tready = 1'b1;
            end
        join
        idle(3);
        check_val("bp_count", got_words.size() - base, 2);
        if (got_words.size() >= base + 2) begin
            check_val("bp_word1", got_words[base], 128'h00000103_00000102_00000101_00000100);
            check_val("bp_word2", got_words[base + 1], 128'h00000107_00000106_00000105_00000104);
        end

        // Sustained streaming: one word every 4 cycles, no stalls.
        base = got_words.size();
        st0 = stalls;
        for (int i = 0; i < 16; i++) send_beat($urandom, 1'b0);
        idle(3);
        check_val("stream_count", got_words.size() - base, 4);
        check_val("stream_stalls", stalls - st0, 0);
        if (got_words.size() >= base + 4)
            for (int i = 0; i < 3; i++)
                check_val("stream_gap", got_cyc[base + i + 1] - got_cyc[base + i], 4);

        // Reset mid-word discards the partial word.
        base = got_words.size();
        send_beat(32'hDEAD, 1'b0); send_beat(32'hBEEF, 1'b0);
        pulse_reset();
        send_beat(32'h1, 1'b0); send_beat(32'h2, 1'b0); send_beat(32'h3, 1'b0); send_beat(32'h4, 1'b0);
        idle(3);
        check_val("rst_mid_count", got_words.size() - base, 1);
        if (got_words.size() > base)
            check_val("rst_mid_word", got_words[base], 128'h00000004_00000003_00000002_00000001);

        // Reset while a completed word is held discards it too.
        m_out_tready = 1'b0;
        base = got_words.size();
        for (int i = 0; i < 4; i++) send_beat(32'h900 + 32'(i), 1'b0);
        idle(2);
        pulse_reset();
        m_out_tready = 1'b1;
        idle(4);
        check_val("rst_hold_count", got_words.size() - base, 0);

        // Randomized traffic with random back-pressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    send_beat($urandom, ($urandom_range(0, 4) == 0));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    m_out_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_out_tready = 1'b1;
        idle(5);
        check_val("final_drained", m_out_tvalid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
